serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller. It sequences a single `full_adder` cell over a WIDTH-bit operand pair, one bit per clock, LSB first. A carry register closes the loop between the cell's `cout` and `cin`. It trades WIDTH+2 cycles of latency for one adder cell, sits between a requesting unit and the arithmetic datapath, and uses a start/busy/done handshake.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_serial_add_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder/subtractor controller:
// FSM state encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full_adder cell walks a WIDTH-bit operand
// pair LSB first, with a start/busy/done handshake around it.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  // Handshake: start is sampled only in IDLE; busy is high for the WIDTH bit
  // cycles, done pulses for one cycle after, and sum/cout/ovf hold until the
  // next operation completes.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the MSB so the result ends up LSB-aligned.
  assign res_nxt = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res   <= res_nxt;
          carry <= fa_co;
          if (cnt == LAST) begin
            // On the final bit the live carry register is the MSB carry-in.
            sum  <= res_nxt;
            cout <= fa_co;
            ovf  <= carry ^ fa_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against an arithmetic
// reference model: handshake timing, held outputs, ignored start, reset abort.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, sub;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;
  state_t       state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q[$];   // {ovf, cout, sum} per accepted operation
  logic [W+1:0] held;       // result the outputs must currently show

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    int ux = x;
    int uy = y;
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int r;
    logic [W-1:0] rs;
    logic c, o;
    if (s) begin
      r  = sx - sy;
      c  = (ux >= uy);
      rs = W'(ux - uy);
    end else begin
      r  = sx + sy;
      c  = ((ux + uy) >= (1 << W));
      rs = W'(ux + uy);
    end
    o = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    return {o, c, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic eb, input logic ed);
    state_t es;
    es = eb ? RUN : (ed ? DONE : IDLE);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".state"}, 32'(state_dbg), 32'(es));
    chk({tag, ".sum"}, 32'(sum), 32'(held[W-1:0]));
    chk({tag, ".cout"}, 32'(cout), 32'(held[W]));
    chk({tag, ".ovf"}, 32'(ovf), 32'(held[W+1]));
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_cycle(tag, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns likewise.
  // poke > 0 pulses start with junk operands in that busy cycle.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input int poke);
    a = x; b = y; sub = s; start = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(negedge clk);
    chk_cycle($sformatf("%s.c0", tag), 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    for (int c = 1; c <= W + 1; c++) begin
      if (c == poke) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      if (c == W + 1) held = exp_q.pop_front();
      chk_cycle($sformatf("%s.c%0d", tag, c), c <= W, c == W + 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    idle_cycles($sformatf("%s.end", tag), 1);
  endtask

  initial begin
    logic [W+1:0] m;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    held = '0;
    #2;
    chk_cycle("reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles("post_reset", 1);

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 0);
    run_op("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 0);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 0);
    run_op("ignore_start", 8'h33, 8'h44, 1'b0, 3);

    // Abort in busy cycle 4 with a one-cycle reset pulse.
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    held = '0;
    #1;
    chk_cycle("abort", 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles("abort_idle", 12);
    run_op("after_abort", 8'h01, 8'h02, 1'b0, 0);

    // start held high: back-to-back operations every W+2 cycles.
    a = 8'hC3; b = 8'h5E; sub = 1'b0;
    m = model(a, b, sub);
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c % 10 == 9) held = m;
      chk_cycle($sformatf("held.c%0d", c), (c % 10 >= 1) && (c % 10 <= 8), c % 10 == 9);
      @(posedge clk); #1;
    end
    start = 1'b0;
    idle_cycles("held_end", 1);

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom),
             (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0));
      idle_cycles("rand_gap", int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
